fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end between the PC and the decode stage.
- Holds the 64-bit fetch PC and drives the word address of the combinational instruction memory (imem, 64 x 32-bit, 6-bit word address).
- Captures the returned word together with its PC into a small prefetch FIFO, and presents entries to decode over a valid/ready handshake.
- A branch redirect flushes the queue and restarts fetch at the target PC.

Parameters:
- N, 32: instruction width in bits; must match imem N.
- DEPTH, 4: queue entries; power of 2, >= 2.
- AW, 6: imem word-address width.
- PC_W, 64: program-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: sampled on the clk rising edge, state cleared when 0.
- imem_addr  out  AW  word address to imem; equals fetch_pc[AW+1:2].
- imem_q  in  N  instruction word from imem, combinational from imem_addr in the same cycle.
- redirect_valid  in  1  branch taken / redirect request.
- redirect_pc  in  PC_W  redirect target byte address.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts head this cycle.
- dec_instr  out  N  head instruction.
- dec_pc  out  PC_W  byte PC of the head instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc=0, queue empty, count=0, dec_valid=0; dec_instr/dec_pc = 0.
  - Reset dominates redirect and handshake.
  - Reset mid-operation discards all entries.
- Push: each cycle with redirect_valid=0 and (count<DEPTH or pop).
  - Entry {fetch_pc, imem_q} is written at the tail.
  - fetch_pc <= fetch_pc+4.
- Pop: dec_valid && dec_ready && !redirect_valid; head advances.
- dec_valid = (count!=0). dec_instr/dec_pc come from the head entry: registered storage, no combinational path from imem_q.
- Latency:
  - First cycle out of reset pushes PC 0.
  - dec_valid rises one cycle later with dec_pc=0.
  - Steady-state throughput is 1 instruction/cycle with dec_ready held at 1.
- Full (count==DEPTH):
  - No push; fetch_pc holds.
  - Simultaneous pop and push is allowed; count unchanged.
- Empty: pop is impossible because dec_valid=0. dec_ready is ignored.
- Redirect (redirect_valid=1):
  - Next cycle: count=0, dec_valid=0, fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00} (low bits forced zero).
  - No push and no pop that cycle; the head offered that cycle is discarded even if dec_ready=1.
  - The first target entry is valid 2 cycles after the redirect edge.
- Back-to-back redirects: the last one wins; the queue stays empty.
- Wrap-around:
  - FIFO read/write pointers are AW-independent log2(DEPTH) bits and wrap modulo DEPTH.
  - fetch_pc is full PC_W arithmetic and wraps at 2^PC_W.
  - imem_addr takes bits [AW+1:2], so PC 256 maps to address 0.
- count never exceeds DEPTH or goes below 0; assertions are required in the bench.

Decomposition:
- Package fetch_pkg:
  - PC_W constant, PC_STEP=4.
  - typedef struct packed fetch_entry_t {logic [PC_W-1:0] pc; logic [N-1:0] instr;}.
- Sub-module fetch_fifo: generic synchronous FIFO with push, pop and synchronous flush; storage of fetch_entry_t; active-low sync reset.
- fetch_queue keeps the PC register, push/pop/redirect control and the imem address slice.

Test Plan:
- Reset then dec_ready=1, bench imem word[i]=32'h1000_0000+i:
  - Cycles 1..5 show dec_pc 0,4,8,12,16.
  - dec_instr 32'h10000000..32'h10000004; dec_valid continuous.
- dec_ready=0 for 8 cycles:
  - count saturates at 4, fetch_pc holds at 16, imem_addr=4.
  - Release dec_ready: dec_pc 0,4,8,12,16 in order with no gap or duplicate.
- Redirect with redirect_pc=0x2B (misaligned) while queue holds 3 entries:
  - Next cycle count=0, dec_valid=0.
  - Following cycle dec_pc=0x28, dec_instr=word[10].
  - Entries that were queued are never accepted.
- Full queue plus dec_ready=1:
  - count stays 4 each cycle; dec_pc increments by 4; one push per pop.
- Address wrap: redirect to 0xF8, run 4 instructions:
  - dec_pc 0xF8, 0xFC, 0x100, 0x104.
  - imem_addr 62, 63, 0, 1; dec_instr = word[62], word[63], word[0], word[1].
- Reset (reset=0 for 1 cycle) asserted with count=3 and redirect_valid=1:
  - Next cycle count=0, fetch_pc=0.
  - After release, first dec_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int N       = 32;
   localparam int PC_W    = 64;
   localparam int PC_STEP = 4;

   // One prefetched instruction together with the byte PC it was fetched from.
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [N-1:0]    instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop and a synchronous flush.
// Handshake: a push is taken when push=1 and the FIFO is not full, or when a
// pop is taken in the same cycle; a pop is taken when pop=1 and count!=0.
// Flush drops every entry and wins over push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  fetch_entry_t                 wdata,
   output fetch_entry_t                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_entry_t      mem_q [DEPTH];
   fetch_entry_t      mem_d [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_q != '0) && !flush;
   assign push_ok = push && (!full || pop_ok) && !flush;

   // Head is read from registered storage; an empty FIFO presents zeros.
   assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

   // Next-state for storage, pointers and occupancy; pointers wrap modulo DEPTH.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the imem word
// address, captures {pc, instr} into a prefetch FIFO and offers the head to
// decode. Decode handshake: an entry transfers when dec_valid && dec_ready
// in a cycle without redirect; dec_valid never depends on dec_ready.
// N and PC_W must match the widths fixed in fetch_pkg.
module fetch_queue #(
   parameter int N     = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int PC_W  = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [AW-1:0]                imem_addr,
   input  logic [N-1:0]                 imem_q,
   input  logic                         redirect_valid,
   input  logic [PC_W-1:0]              redirect_pc,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [N-1:0]                 dec_instr,
   output logic [PC_W-1:0]              dec_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH+1);

   fetch_pkg::fetch_entry_t  wr_entry;
   fetch_pkg::fetch_entry_t  rd_entry;
   logic [PC_W-1:0]          fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]         fifo_count;
   logic                     fifo_full;
   logic                     push;
   logic                     pop;
   logic                     unused_bits;

   // A redirect freezes both ends of the queue for the cycle it is seen.
   assign dec_valid = (fifo_count != '0);
   assign pop       = dec_valid && dec_ready && !redirect_valid;
   assign push      = !redirect_valid && (!fifo_full || pop);

   assign wr_entry.pc    = fetch_pc_q;
   assign wr_entry.instr = imem_q;

   assign imem_addr = fetch_pc_q[AW+1:2];
   assign dec_instr = rd_entry.instr;
   assign dec_pc    = rd_entry.pc;
   assign count     = fifo_count;

   // Byte-offset and high PC bits never reach imem.
   assign unused_bits = ^{redirect_pc[1:0], fetch_pc_q[1:0], fetch_pc_q[PC_W-1:AW+2]};

   // Next fetch PC: redirect target (word aligned), else step on every push.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + PC_W'(fetch_pkg::PC_STEP);
      end
   end

   // Fetch PC register; reset dominates redirect.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .count (fifo_count),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 6;
   localparam int PC_W  = 64;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             redirect_valid = 1'b0;
   logic [PC_W-1:0]  redirect_pc = '0;
   logic             dec_ready = 1'b0;
   logic [AW-1:0]    imem_addr;
   logic [N-1:0]     imem_q;
   logic             dec_valid;
   logic [N-1:0]     dec_instr;
   logic [PC_W-1:0]  dec_pc;
   logic [CW-1:0]    count;

   logic [N-1:0]     word [64];

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [PC_W-1:0]  exp_q[$];
   logic [N-1:0]     exp_i_q[$];
   logic [PC_W-1:0]  m_pc = '0;
   bit               started = 1'b0;
   bit               m_pop;

   fetch_queue #(.N(N), .DEPTH(DEPTH), .AW(AW), .PC_W(PC_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_q         (imem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .count          (count)
   );

   // clock and imem
   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 64; i++) word[i] = 32'h1000_0000 + i;
   end

   assign imem_q = word[imem_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Reference model: a plain queue of {pc, instr}, updated at each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         started = 1'b1;
         if (!reset) begin
            exp_q.delete();
            exp_i_q.delete();
            m_pc = '0;
         end else if (redirect_valid) begin
            exp_q.delete();
            exp_i_q.delete();
            m_pc = redirect_pc & ~64'd3;
         end else begin
            m_pop = (exp_q.size() != 0) && dec_ready;
            if (m_pop) begin
               void'(exp_q.pop_front());
               void'(exp_i_q.pop_front());
            end
            if (exp_q.size() < DEPTH) begin
               exp_q.push_back(m_pc);
               exp_i_q.push_back(word[m_pc[7:2]]);
               m_pc = m_pc + 64'd4;
            end
         end
      end
   end

   // Per-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         total++;
         assert (count <= DEPTH) else begin
            bad++;
            $display("FAIL count_bound: got=%0d want<=%0d at t=%0t", count, DEPTH, $time);
         end
         check("m_count", 64'(count), 64'(exp_q.size()));
         check("m_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
         check("m_imem_addr", 64'(imem_addr), 64'(m_pc[7:2]));
         if (exp_q.size() != 0) begin
            check("m_dec_pc", dec_pc, exp_q[0]);
            check("m_dec_instr", 64'(dec_instr), 64'(exp_i_q[0]));
         end
      end
   end

   logic [63:0] wrap_pc   [4];
   logic [31:0] wrap_word [4];
   logic [5:0]  wrap_addr [4];

   initial begin
      wrap_pc   = '{64'hF8, 64'hFC, 64'h100, 64'h104};
      wrap_word = '{32'h1000_003E, 32'h1000_003F, 32'h1000_0000, 32'h1000_0001};
      wrap_addr = '{6'd63, 6'd0, 6'd1, 6'd2};

      // reset state
      cyc(3);
      check("rst_count", 64'(count), 64'd0);
      check("rst_valid", 64'(dec_valid), 64'd0);
      check("rst_dec_pc", dec_pc, 64'd0);
      check("rst_dec_instr", 64'(dec_instr), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);

      // streaming from reset, decode always ready
      reset = 1'b1;
      dec_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("stream_valid", 64'(dec_valid), 64'd1);
         check("stream_pc", dec_pc, 64'(4 * i));
         check("stream_instr", 64'(dec_instr), 64'(32'h1000_0000 + i));
      end

      // stall decode until the queue saturates, then drain while full
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      dec_ready = 1'b0;
      cyc(8);
      check("stall_count", 64'(count), 64'd4);
      check("stall_imem_addr", 64'(imem_addr), 64'd4);
      check("stall_head_pc", dec_pc, 64'd0);
      dec_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         cyc(1);
         check("drain_pc", dec_pc, 64'(4 * i));
         check("drain_full_count", 64'(count), 64'd4);
      end

      // misaligned redirect with three queued entries
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      dec_ready = 1'b0;
      cyc(3);
      check("pre_redir_count", 64'(count), 64'd3);
      redirect_valid = 1'b1;
      redirect_pc = 64'h2B;
      dec_ready = 1'b1;
      cyc(1);
      redirect_valid = 1'b0;
      check("redir_count", 64'(count), 64'd0);
      check("redir_valid", 64'(dec_valid), 64'd0);
      check("redir_imem_addr", 64'(imem_addr), 64'd10);
      cyc(1);
      check("redir_first_valid", 64'(dec_valid), 64'd1);
      check("redir_first_pc", dec_pc, 64'h28);
      check("redir_first_instr", 64'(dec_instr), 64'h1000_000A);

      // imem address wrap past word 63
      redirect_valid = 1'b1;
      redirect_pc = 64'hF8;
      cyc(1);
      redirect_valid = 1'b0;
      check("wrap_addr0", 64'(imem_addr), 64'd62);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         check("wrap_pc", dec_pc, wrap_pc[i]);
         check("wrap_instr", 64'(dec_instr), 64'(wrap_word[i]));
         check("wrap_addr", 64'(imem_addr), 64'(wrap_addr[i]));
      end

      // reset together with redirect while three entries are queued
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      dec_ready = 1'b0;
      cyc(3);
      check("pre_rst_count", 64'(count), 64'd3);
      reset = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 64'h40;
      dec_ready = 1'b1;
      cyc(1);
      check("rst2_count", 64'(count), 64'd0);
      check("rst2_valid", 64'(dec_valid), 64'd0);
      check("rst2_imem_addr", 64'(imem_addr), 64'd0);
      reset = 1'b1;
      redirect_valid = 1'b0;
      cyc(1);
      check("rst2_first_valid", 64'(dec_valid), 64'd1);
      check("rst2_first_pc", dec_pc, 64'd0);

      // randomized traffic, checked every cycle by the model compare
      repeat (3000) begin
         dec_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 39) == 0);
         reset = ($urandom_range(0, 199) != 0);
         case ($urandom_range(0, 2))
            0:       redirect_pc = {$urandom, $urandom};
            1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            default: redirect_pc = 64'($urandom_range(0, 511));
         endcase
         cyc(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
